pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Sequences the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Drives the PC enable and a per-pipe-register enable/flush for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves three hazard classes: load-use stalls, wrong-path flushes after a branch/jump/jr redirect resolved in MEM, and external freeze requests.
- Also provides a halt/drain/resume sequence for debug single-stepping. Sits beside the forwarding unit; the pipe registers' enable inputs are driven from this block instead of constant 1.

Parameters:
- DRAIN_CYCLES, 4, number of bubble-retire cycles between halt acceptance and halted; range 1..15.
- CNT_WIDTH, 32, width of performance counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  1 = ID instruction reads rt (R-type, beq/bne, sw).
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rt  in  5  destination rt of the EX load.
- mem_redirect  in  1  MEM stage changes PC (taken beq/bne, j, jal, jr).
- ext_stall  in  1  freeze whole pipeline (e.g. slow memory); level-sensitive.
- halt_req  in  1  request drain and halt.
- resume_req  in  1  leave halted state.
- pc_en  out  1  PC register load enable.
- if_id_en  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads zero (nop) on next edge.
- id_ex_en  out  1  ID/EX load enable.
- id_ex_flush  out  1  ID/EX loads zero.
- ex_mem_en  out  1  EX/MEM load enable.
- ex_mem_flush  out  1  EX/MEM loads zero.
- mem_wb_en  out  1  MEM/WB load enable.
- halted  out  1  pipeline empty and held.
- stall_count  out  CNT_WIDTH  load-use stall cycles.
- flush_count  out  CNT_WIDTH  redirect flush events.

Behaviour:
- FSM states: RUN, DRAIN, HALTED. State and drain counter are registered. All enables and flushes are combinational from state and inputs, so they act on the same edge.
- Flush has priority over enable in the pipe register: flush=1 with en=1 loads zero.
- Reset low: on the next edge state=RUN, drain_cnt=0, counters=0. While reset is low, the combinational outputs are pc_en=0, all *_en=1, all *_flush=1, halted=0.
- load_use = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- Priority per cycle: ext_stall > mem_redirect > load_use > FSM default.
- ext_stall=1, any state:
  - All enables 0, all flushes 0.
  - FSM, drain counter and perf counters hold.
  - halt_req and resume_req are ignored.
- mem_redirect=1 (not frozen):
  - pc_en=1; all *_en=1; if_id_flush=1, id_ex_flush=1, ex_mem_flush=1, squashing the 3 wrong-path instructions.
  - load_use is ignored that cycle.
  - In DRAIN, the redirect is accepted and drain_cnt reloads to DRAIN_CYCLES-1.
- load_use (RUN, no redirect):
  - pc_en=0, if_id_en=0, id_ex_flush=1; other stages enabled.
  - Lasts exactly 1 cycle, because the load advances to MEM and the forwarding unit supplies the data.
- RUN default: all *_en=1, flushes 0, pc_en=1.
  - halt_req=1 with no redirect and no load_use → DRAIN, drain_cnt=DRAIN_CYCLES-1.
  - If the halt is blocked by redirect or load_use, it is retried while halt_req is held.
- DRAIN:
  - pc_en=0 and if_id_flush=1, so the IF instruction is discarded and the PC holds its address for refetch.
  - drain_cnt decrements each non-frozen cycle; at 0 → HALTED.
  - load_use in DRAIN: if_id_en=0, if_id_flush=0, id_ex_flush=1, and drain_cnt does not decrement.
- HALTED:
  - halted=1, pc_en=0, if_id_en=0, id_ex_flush=1; remaining stages enabled.
  - resume_req=1 → RUN on the next edge; halted drops the same edge.
  - halt_req is ignored while HALTED.
- resume_req is ignored outside HALTED. Simultaneous halt_req and resume_req in HALTED → resume.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - stall_count increments on each non-frozen load_use cycle.
  - flush_count increments on each non-frozen mem_redirect cycle.
  - Both saturate at all-ones and clear on reset.
- Undefined: both outputs tie to 0 and no counter flops are built.

Test Plan:
- lw $t0 in EX (ex_mem_read=1, ex_rt=8), ID add with id_rs=8 → one cycle: pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables=1. The same case with ex_rt=0 → no stall.
- mem_redirect=1 together with load_use=1 → pc_en=1, if_id_flush=id_ex_flush=ex_mem_flush=1, no stall; flush_count=1 (feature on).
- ext_stall held 3 cycles during a load_use → all enables 0 for 3 cycles, then exactly one stall cycle once released; stall_count=1.
- halt_req pulse in RUN, DRAIN_CYCLES=4 → halted=1 exactly 4 edges after entering DRAIN; pc_en=0 throughout; resume_req → pc_en=1 the next cycle.
- Redirect during the 2nd DRAIN cycle → drain_cnt reloads to 3, and halted asserts 4 cycles after the redirect.
- Reset driven low mid-DRAIN → next edge: state RUN, halted=0, counters 0; the PC does not advance while reset is low.

Source files
------------

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: ID/EX/MEM hazard info and debug requests in, pipe-register enables/flushes out.
// The pipeline side uses the master modport and the controller uses the slave modport.
interface pipeline_hazard_controller_if #(
  parameter int CNT_WIDTH = 32
);
  // halt_req/resume_req are level requests sampled on each non-frozen edge. The requester keeps
  // halt_req high until it sees halted or the drain begin; a blocked request is retried
  // automatically. Because these are not valid/ready pairs, no ready signal is returned.
  logic [4:0]           id_rs;
  logic [4:0]           id_rt;
  logic                 id_uses_rt;
  logic                 ex_mem_read;
  logic [4:0]           ex_rt;
  logic                 mem_redirect;
  logic                 ext_stall;
  logic                 halt_req;
  logic                 resume_req;
  logic                 pc_en;
  logic                 if_id_en;
  logic                 if_id_flush;
  logic                 id_ex_en;
  logic                 id_ex_flush;
  logic                 ex_mem_en;
  logic                 ex_mem_flush;
  logic                 mem_wb_en;
  logic                 halted;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;
  logic [1:0]           dbg_state;
  logic [3:0]           dbg_drain_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, mem_redirect, ext_stall,
           halt_req, resume_req,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush,
           mem_wb_en, halted, stall_count, flush_count, dbg_state, dbg_drain_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, mem_redirect, ext_stall,
           halt_req, resume_req,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush,
           mem_wb_en, halted, stall_count, flush_count, dbg_state, dbg_drain_cnt
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// 5-stage MIPS pipeline sequencer: load-use stalls, redirect flushes, freeze, and halt/drain/resume.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush performance counters.
module pipeline_hazard_controller #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_WIDTH    = 32
) (
  input logic                         clk,
  input logic                         reset,
  pipeline_hazard_controller_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] drain_cnt_q, drain_cnt_d;

  logic load_use;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic ex_mem_en, ex_mem_flush, mem_wb_en;

  assign load_use = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                    ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    ex_mem_flush = 1'b0;
    mem_wb_en    = 1'b1;

    if (!reset) begin
      // Hold the PC and fill every register with nops while reset is asserted.
      pc_en        = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = ST_RUN;
      drain_cnt_d  = 4'd0;
    end else if (bus.ext_stall) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (bus.mem_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      if (state_q == ST_DRAIN) drain_cnt_d = DRAIN_LOAD;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (bus.halt_req) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          pc_en = 1'b0;
          if (load_use) begin
            // The load still has to reach MEM, so the drain count waits a cycle.
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else begin
            if_id_flush = 1'b1;
            if (drain_cnt_q == 4'd0) state_d = ST_HALTED;
            else                     drain_cnt_d = drain_cnt_q - 4'd1;
          end
        end
        ST_HALTED: begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          if (bus.resume_req) state_d = ST_RUN;
        end
        default: begin
          state_d     = ST_RUN;
          drain_cnt_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    drain_cnt_q <= drain_cnt_d;
  end

  assign bus.pc_en         = pc_en;
  assign bus.if_id_en      = if_id_en;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_en      = id_ex_en;
  assign bus.id_ex_flush   = id_ex_flush;
  assign bus.ex_mem_en     = ex_mem_en;
  assign bus.ex_mem_flush  = ex_mem_flush;
  assign bus.mem_wb_en     = mem_wb_en;
  assign bus.halted        = reset && (state_q == ST_HALTED);
  assign bus.dbg_state     = state_q;
  assign bus.dbg_drain_cnt = drain_cnt_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                 stall_inc, flush_inc;

  assign stall_inc = !bus.ext_stall && !bus.mem_redirect && load_use;
  assign flush_inc = !bus.ext_stall && bus.mem_redirect;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_inc && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_count = stall_cnt_q;
  assign bus.flush_count = flush_cnt_q;
`else
  assign bus.stall_count = {CNT_WIDTH{1'b0}};
  assign bus.flush_count = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller; expected output vectors flow through a scoreboard queue.
// Counter expectations follow HAZARD_PERF_CNT_EN the same way the design build does.
module tb_pipeline_hazard_controller;
  localparam int CW = 32;

  // Output vector: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_en, halted}
  localparam logic [8:0] O_RUN  = 9'b110101010;
  localparam logic [8:0] O_LU   = 9'b000111010;
  localparam logic [8:0] O_RDR  = 9'b111111110;
  localparam logic [8:0] O_FRZ  = 9'b000000000;
  localparam logic [8:0] O_FRZH = 9'b000000001;
  localparam logic [8:0] O_DRN  = 9'b011101010;
  localparam logic [8:0] O_HLT  = 9'b000111011;
  localparam logic [8:0] O_RST  = 9'b011111110;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_hazard_controller_if #(.CNT_WIDTH(CW)) bus ();

  pipeline_hazard_controller #(
    .DRAIN_CYCLES(4),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [8:0]  exp_q[$];
  logic [CW-1:0] exp_stall = '0;
  logic [CW-1:0] exp_flush = '0;

  function automatic logic [8:0] outs_now();
    return {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en, bus.id_ex_flush,
            bus.ex_mem_en, bus.ex_mem_flush, bus.mem_wb_en, bus.halted};
  endfunction

  function automatic logic spec_load_use(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic uses, input logic mr, input logic [4:0] ert);
    return mr && (ert != 5'd0) && ((ert == rs) || (uses && (ert == rt)));
  endfunction

  // driver: drive at negedge, check just after, then advance past the next posedge
  task automatic step(input string name, input logic [4:0] rs, input logic [4:0] rt,
                      input logic uses, input logic mr, input logic [4:0] ert,
                      input logic rdr, input logic ext, input logic hlt, input logic res,
                      input logic [8:0] exp);
    logic [8:0]    obs;
    logic [8:0]    e;
    logic [CW-1:0] es, ef;
    @(negedge clk);
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_uses_rt   = uses;
    bus.ex_mem_read  = mr;
    bus.ex_rt        = ert;
    bus.mem_redirect = rdr;
    bus.ext_stall    = ext;
    bus.halt_req     = hlt;
    bus.resume_req   = res;
    exp_q.push_back(exp);
    #1;
    obs = outs_now();
    e   = exp_q.pop_front();
    n_tests++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL %s outputs: got %b expected %b", name, obs, e);
    end
`ifdef HAZARD_PERF_CNT_EN
    es = exp_stall;
    ef = exp_flush;
`else
    es = '0;
    ef = '0;
`endif
    n_tests++;
    if (bus.stall_count !== es) begin
      n_fail++;
      $display("FAIL %s stall_count: got %0d expected %0d", name, bus.stall_count, es);
    end
    n_tests++;
    if (bus.flush_count !== ef) begin
      n_fail++;
      $display("FAIL %s flush_count: got %0d expected %0d", name, bus.flush_count, ef);
    end
    if (!reset) begin
      exp_stall = '0;
      exp_flush = '0;
    end else if (!ext) begin
      if (rdr) begin
        if (exp_flush != '1) exp_flush = exp_flush + 1'b1;
      end else if (spec_load_use(rs, rt, uses, mr, ert)) begin
        if (exp_stall != '1) exp_stall = exp_stall + 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string name, input logic [8:0] exp);
    step(name, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
  endtask

  task automatic ctl(input string name, input logic rdr, input logic ext, input logic hlt,
                     input logic res, input logic [8:0] exp);
    step(name, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, rdr, ext, hlt, res, exp);
  endtask

  // lw $t0 in EX, add reading $t0 in ID
  task automatic lu(input string name, input logic rdr, input logic ext, input logic hlt,
                    input logic [8:0] exp);
    step(name, 5'd8, 5'd9, 1'b1, 1'b1, 5'd8, rdr, ext, hlt, 1'b0, exp);
  endtask

  task automatic check_state(input string name, input logic [1:0] st, input logic [3:0] cnt);
    n_tests++;
    if (bus.dbg_state !== st || bus.dbg_drain_cnt !== cnt) begin
      n_fail++;
      $display("FAIL %s state/drain_cnt: got %0d/%0d expected %0d/%0d",
               name, bus.dbg_state, bus.dbg_drain_cnt, st, cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0; bus.ex_mem_read = 1'b0;
    bus.ex_rt = '0; bus.mem_redirect = 1'b0; bus.ext_stall = 1'b0;
    bus.halt_req = 1'b0; bus.resume_req = 1'b0;
    @(posedge clk);
    #1;
    check_state("reset_state", 2'd0, 4'd0);
    idle("reset_idle", O_RST);
    ctl("reset_redirect", 1'b1, 1'b0, 1'b0, 1'b0, O_RST);
    ctl("reset_over_freeze", 1'b0, 1'b1, 1'b0, 1'b0, O_RST);
    lu("reset_over_load_use", 1'b0, 1'b0, 1'b1, O_RST);
    reset = 1'b1;
    idle("run_after_reset", O_RUN);
    check_state("run_after_reset_state", 2'd0, 4'd0);
  endtask

  task automatic test_load_use();
    logic [4:0] rs, rt, ert;
    logic       uses, mr;
    lu("lu_rs_match", 1'b0, 1'b0, 1'b0, O_LU);
    idle("lu_released", O_RUN);
    step("lu_ex_rt_zero", 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN);
    step("lu_rt_used", 5'd3, 5'd12, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, O_LU);
    step("lu_rt_unused", 5'd3, 5'd12, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN);
    step("lu_not_load", 5'd8, 5'd8, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN);
    for (int i = 0; i < 24; i++) begin
      rs   = 5'($urandom_range(0, 3));
      rt   = 5'($urandom_range(0, 3));
      ert  = 5'($urandom_range(0, 3));
      uses = 1'($urandom_range(0, 1));
      mr   = 1'($urandom_range(0, 1));
      step("lu_random", rs, rt, uses, mr, ert, 1'b0, 1'b0, 1'b0, 1'b0,
           spec_load_use(rs, rt, uses, mr, ert) ? O_LU : O_RUN);
    end
  endtask

  task automatic test_redirect();
    lu("redirect_beats_load_use", 1'b1, 1'b0, 1'b0, O_RDR);
    idle("redirect_done", O_RUN);
    ctl("redirect_plain", 1'b1, 1'b0, 1'b0, 1'b0, O_RDR);
    ctl("redirect_blocks_halt", 1'b1, 1'b0, 1'b1, 1'b0, O_RDR);
    check_state("redirect_blocks_halt_state", 2'd0, 4'd0);
  endtask

  task automatic test_freeze();
    lu("freeze_lu_1", 1'b0, 1'b1, 1'b0, O_FRZ);
    lu("freeze_lu_2", 1'b0, 1'b1, 1'b0, O_FRZ);
    lu("freeze_lu_3", 1'b1, 1'b1, 1'b1, O_FRZ);
    check_state("freeze_ignores_halt", 2'd0, 4'd0);
    lu("freeze_release_stall", 1'b0, 1'b0, 1'b0, O_LU);
    idle("freeze_after_stall", O_RUN);
  endtask

  task automatic test_halt();
    ctl("resume_ignored_in_run", 1'b0, 1'b0, 1'b0, 1'b1, O_RUN);
    check_state("resume_ignored_state", 2'd0, 4'd0);
    lu("halt_blocked_by_lu", 1'b0, 1'b0, 1'b1, O_LU);
    ctl("halt_accept", 1'b0, 1'b0, 1'b1, 1'b0, O_RUN);
    check_state("drain_entered", 2'd1, 4'd3);
    idle("drain_1", O_DRN);
    idle("drain_2", O_DRN);
    ctl("drain_frozen", 1'b0, 1'b1, 1'b0, 1'b0, O_FRZ);
    idle("drain_3", O_DRN);
    idle("drain_4", O_DRN);
    check_state("halted_state", 2'd2, 4'd0);
    ctl("halted_ignores_halt", 1'b0, 1'b0, 1'b1, 1'b0, O_HLT);
    ctl("halted_frozen", 1'b0, 1'b1, 1'b0, 1'b1, O_FRZH);
    ctl("halted_resume_and_halt", 1'b0, 1'b0, 1'b1, 1'b1, O_HLT);
    idle("resumed_run", O_RUN);
  endtask

  task automatic test_drain_redirect();
    ctl("dr_halt", 1'b0, 1'b0, 1'b1, 1'b0, O_RUN);
    idle("dr_drain_1", O_DRN);
    ctl("dr_redirect", 1'b1, 1'b0, 1'b0, 1'b0, O_RDR);
    check_state("dr_reload", 2'd1, 4'd3);
    idle("dr_after_1", O_DRN);
    lu("dr_load_use", 1'b0, 1'b0, 1'b0, O_LU);
    check_state("dr_lu_holds_cnt", 2'd1, 4'd2);
    idle("dr_after_2", O_DRN);
    idle("dr_after_3", O_DRN);
    idle("dr_after_4", O_DRN);
    idle("dr_halted", O_HLT);
    ctl("dr_resume", 1'b0, 1'b0, 1'b0, 1'b1, O_HLT);
    idle("dr_run", O_RUN);
  endtask

  task automatic test_reset_mid_drain();
    ctl("rmd_halt", 1'b0, 1'b0, 1'b1, 1'b0, O_RUN);
    idle("rmd_drain_1", O_DRN);
    idle("rmd_drain_2", O_DRN);
    reset = 1'b0;
    idle("rmd_reset_low", O_RST);
    reset = 1'b1;
    check_state("rmd_state", 2'd0, 4'd0);
    idle("rmd_run", O_RUN);
    ctl("rmd_halt_again", 1'b0, 1'b0, 1'b1, 1'b0, O_RUN);
    idle("rmd_drain_again", O_DRN);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_freeze();
    test_halt();
    test_drain_redirect();
    test_reset_mid_drain();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
